// File: rtl/trd_fetch_unit.sv
// Multithreaded fetch stage: per-thread PC file, round-robin issue,
// decode tracking, redirect/miss replay and miss blocking.
module trd_fetch_unit #(
  parameter int NUM_TRD = 8,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int TRD_W = $clog2(NUM_TRD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_TRD-1:0] trd_en,
  input  logic               init_vld,
  input  logic [TRD_W-1:0]   init_trd,
  input  logic [PC_W-1:0]    init_pc,
  input  logic               jmp,
  input  logic [TRD_W-1:0]   jmp_trd,
  input  logic [PC_W-1:0]    jmp_pc,
  input  logic               i_miss,
  input  logic               d_miss,
  input  logic [TRD_W-1:0]   d_miss_trd,
  input  logic [PC_W-1:0]    d_miss_pc,
  input  logic               fill_vld,
  input  logic [TRD_W-1:0]   fill_trd,
  input  logic               hold,
  input  logic               stall,
  output logic               i_rd,
  output logic [PC_W-1:0]    i_addr,
  output logic [TRD_W-1:0]   i_trd,
  output logic               dec_vld,
  output logic [TRD_W-1:0]   dec_trd,
  output logic [PC_W-1:0]    dec_pc,
  output logic               flush_id,
  output logic [NUM_TRD-1:0] blocked
);

  logic [PC_W-1:0]    pc_q [NUM_TRD];
  logic [NUM_TRD-1:0] blk_q;
  logic [NUM_TRD-1:0] blk_d;
  logic [NUM_TRD-1:0] elig;
  logic [TRD_W-1:0]   last_q;
  logic [TRD_W-1:0]   sel;
  logic [TRD_W-1:0]   cand;
  logic               im_hit;
  int                 idx;

  assign im_hit = i_miss & dec_vld;

  always_comb begin
    elig = '0;
    for (int t = 0; t < NUM_TRD; t++) begin
      elig[t] = trd_en[t] & ~blk_q[t]
              & ~(jmp && jmp_trd == TRD_W'(t))
              & ~(d_miss && d_miss_trd == TRD_W'(t))
              & ~(im_hit && dec_trd == TRD_W'(t))
              & ~(init_vld && init_trd == TRD_W'(t));
    end
  end

  // Lowest offset from last wins; offset NUM_TRD is last itself.
  always_comb begin
    sel  = last_q;
    idx  = 0;
    cand = '0;
    if (!(hold && elig[last_q])) begin
      for (int k = NUM_TRD - 1; k >= 1; k--) begin
        idx  = (int'(last_q) + k) % NUM_TRD;
        cand = TRD_W'(idx);
        if (elig[cand]) sel = cand;
      end
    end
  end

  assign i_rd   = (|elig) & ~stall;
  assign i_trd  = sel;
  assign i_addr = pc_q[sel];

  assign flush_id = dec_vld & (i_miss
                  | (d_miss && d_miss_trd == dec_trd)
                  | (jmp && jmp_trd == dec_trd));

  // Init clear is applied last so it overrides a same-cycle miss.
  always_comb begin
    blk_d = blk_q;
    if (fill_vld) blk_d[fill_trd] = 1'b0;
    if (d_miss)   blk_d[d_miss_trd] = 1'b1;
    if (im_hit)   blk_d[dec_trd] = 1'b1;
    if (init_vld) blk_d[init_trd] = 1'b0;
  end

  assign blocked = blk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TRD; t++)
        pc_q[t] <= (t == 0) ? RESET_PC : '0;
    end else begin
      for (int t = 0; t < NUM_TRD; t++) begin
        if (init_vld && init_trd == TRD_W'(t))
          pc_q[t] <= init_pc;
        else if (d_miss && d_miss_trd == TRD_W'(t))
          pc_q[t] <= d_miss_pc;
        else if (jmp && jmp_trd == TRD_W'(t))
          pc_q[t] <= jmp_pc;
        else if (im_hit && dec_trd == TRD_W'(t))
          pc_q[t] <= dec_pc;
        else if (i_rd && sel == TRD_W'(t))
          pc_q[t] <= pc_q[t] + PC_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q  <= '0;
      last_q <= TRD_W'(NUM_TRD - 1);
    end else begin
      blk_q <= blk_d;
      if (i_rd) last_q <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_vld <= 1'b0;
      dec_trd <= '0;
      dec_pc  <= '0;
    end else if (i_rd) begin
      dec_vld <= 1'b1;
      dec_trd <= sel;
      dec_pc  <= pc_q[sel];
    end else if (stall) begin
      dec_vld <= dec_vld & ~flush_id;
    end else begin
      dec_vld <= 1'b0;
    end
  end

endmodule
